// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, MEM-stage resolve and statistics signals of the BTB predictor.
interface branch_predictor_if #(
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
);
    logic              en;
    logic [PC_W-1:0]   fetch_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_target;
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport slave (
        input  en, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts
    );
    modport master (
        output en, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, mispredict detection and stats.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int STAT_W  = 16
) (
    input logic                CLK,
    input logic                nRST,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [STAT_W-1:0]  r_branches;
    logic [STAT_W-1:0]  r_mispredicts;

    logic [IDX_W-1:0] w_fidx;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_fhit;
    logic             w_uhit;
    logic             w_commit;
    logic             w_mis;
    logic [1:0]       w_uctr;
    logic [1:0]       w_ctr_next;
    logic             w_unused;

    assign w_fidx   = bp.fetch_pc[IDX_W+1:2];
    assign w_uidx   = bp.upd_pc[IDX_W+1:2];
    assign w_utag   = bp.upd_pc[PC_W-1:IDX_W+2];
    assign w_fhit   = r_valid[w_fidx] && (r_tag[w_fidx] == bp.fetch_pc[PC_W-1:IDX_W+2]);
    assign w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_commit = bp.upd_valid && bp.en;
    assign w_uctr   = r_ctr[w_uidx];
    assign w_unused = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

    assign w_ctr_next = bp.upd_taken ? ((w_uctr == 2'b11) ? w_uctr : w_uctr + 2'b01)
                                     : ((w_uctr == 2'b00) ? w_uctr : w_uctr - 2'b01);

    assign w_mis = bp.upd_valid && ((bp.upd_pred_taken != bp.upd_taken) ||
                                    (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));

    // Reads see pre-update table contents; no write-to-read bypass.
    assign bp.pred_taken       = w_fhit && r_ctr[w_fidx][1];
    assign bp.pred_target      = bp.pred_taken ? r_target[w_fidx] : bp.fetch_pc + PC_W'(4);
    assign bp.mispredict       = w_mis;
    assign bp.redirect_pc      = bp.upd_taken ? bp.upd_target : bp.upd_pc + PC_W'(4);
    assign bp.stat_branches    = r_branches;
    assign bp.stat_mispredicts = r_mispredicts;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (w_commit) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_next;
                if (bp.upd_taken) r_target[w_uidx] <= bp.upd_target;
            end else if (bp.upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bp.upd_target;
                r_ctr[w_uidx]    <= 2'b10;
            end
            if (!(&r_branches)) r_branches <= r_branches + STAT_W'(1);
            if (w_mis && !(&r_mispredicts)) r_mispredicts <= r_mispredicts + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table, saturation/async-reset sequence and randomized model check.
module tb_branch_predictor;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic nRST_s = 1'b0;
    always #5 CLK = ~CLK;

    branch_predictor_if #(.PC_W(32), .STAT_W(16)) bpi ();
    branch_predictor_if #(.PC_W(32), .STAT_W(4))  bps ();

    branch_predictor #(.ENTRIES(16), .PC_W(32), .STAT_W(16)) dut   (.CLK(CLK), .nRST(nRST),   .bp(bpi.slave));
    branch_predictor #(.ENTRIES(16), .PC_W(32), .STAT_W(4))  dut_s (.CLK(CLK), .nRST(nRST_s), .bp(bps.slave));

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] en, fpc, uv, upc, ut, utgt, upt, uptgt;
        logic [31:0] ept, eptgt, emis, eredir, ebr, emc;
    } vec_t;
    vec_t vt [20];

    // Reference model: one slot per index remembering the full word address of its occupant.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_br;
    int          m_mc;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_word[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_br = 0; m_mc = 0;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && ((32'(m_word[i]) >> 4) == (pc >> 6));
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        return bpi.upd_valid && ((bpi.upd_pred_taken != bpi.upd_taken) ||
                                 (bpi.upd_taken && bpi.upd_pred_target != bpi.upd_target));
    endfunction

    function automatic void m_commit();
        int i;
        if (!(bpi.upd_valid && bpi.en)) return;
        i = m_idx(bpi.upd_pc);
        if (m_hit(bpi.upd_pc)) begin
            m_ctr[i] = bpi.upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (bpi.upd_taken) m_tgt[i] = bpi.upd_target;
        end else if (bpi.upd_taken) begin
            m_valid[i] = 1; m_word[i] = bpi.upd_pc[31:2]; m_tgt[i] = bpi.upd_target; m_ctr[i] = 2;
        end
        if (m_br < 65535) m_br++;
        if (m_mis() && m_mc < 65535) m_mc++;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p = 32'($urandom_range(0, 127)) << 2;
        if ($urandom_range(0, 15) == 0) p = p | 32'hFFFF_FE00;
        if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
        return p;
    endfunction

    initial begin
        vt[0]  = '{1, 'h40, 0, 0,    0, 0,     0, 0,      0, 'h44,  0, 4,     0, 0};
        vt[1]  = '{1, 'h40, 1, 'h40, 1, 'h100, 0, 'h44,   0, 'h44,  1, 'h100, 0, 0};
        vt[2]  = '{1, 'h40, 1, 'h40, 0, 0,     1, 'h100,  1, 'h100, 1, 'h44,  1, 1};
        vt[3]  = '{1, 'h40, 1, 'h40, 0, 0,     0, 'h44,   0, 'h44,  0, 'h44,  2, 2};
        vt[4]  = '{1, 'h40, 1, 'h40, 1, 'h100, 0, 'h44,   0, 'h44,  1, 'h100, 3, 2};
        vt[5]  = '{1, 'h40, 1, 'h40, 1, 'h100, 0, 'h44,   0, 'h44,  1, 'h100, 4, 3};
        vt[6]  = '{1, 'h40, 0, 0,    0, 0,     0, 0,      1, 'h100, 0, 4,     5, 4};
        vt[7]  = '{1, 'h80, 0, 0,    0, 0,     0, 0,      0, 'h84,  0, 4,     5, 4};
        vt[8]  = '{1, 'h40, 1, 'h80, 1, 'h200, 0, 'h84,   1, 'h100, 1, 'h200, 5, 4};
        vt[9]  = '{1, 'h40, 0, 0,    0, 0,     0, 0,      0, 'h44,  0, 4,     6, 5};
        vt[10] = '{1, 'h80, 0, 0,    0, 0,     0, 0,      1, 'h200, 0, 4,     6, 5};
        vt[11] = '{0, 'h80, 1, 'h80, 0, 0,     1, 'h200,  1, 'h200, 1, 'h84,  6, 5};
        vt[12] = '{0, 'h80, 1, 'h80, 0, 0,     1, 'h200,  1, 'h200, 1, 'h84,  6, 5};
        vt[13] = '{1, 'h80, 0, 0,    0, 0,     0, 0,      1, 'h200, 0, 4,     6, 5};
        vt[14] = '{1, 'h80, 1, 'h80, 1, 'h300, 1, 'h200,  1, 'h200, 1, 'h300, 6, 5};
        vt[15] = '{1, 'h80, 0, 0,    0, 0,     0, 0,      1, 'h300, 0, 4,     7, 6};
        vt[16] = '{1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0,    0, 0,     0, 4,     7, 6};
        vt[17] = '{0, 'h40, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 'h44,  0, 0,     7, 6};
        vt[18] = '{1, 'h80, 1, 'h80, 1, 'h300, 1, 'h300,  1, 'h300, 0, 'h300, 7, 6};
        vt[19] = '{1, 'h80, 0, 0,    0, 0,     0, 0,      1, 'h300, 0, 4,     8, 6};

        bpi.en = 0; bpi.fetch_pc = '0; bpi.upd_valid = 0; bpi.upd_pc = '0; bpi.upd_taken = 0;
        bpi.upd_target = '0; bpi.upd_pred_taken = 0; bpi.upd_pred_target = '0;
        bps.en = 0; bps.fetch_pc = 32'h40; bps.upd_valid = 0; bps.upd_pc = 32'h40; bps.upd_taken = 1;
        bps.upd_target = 32'h100; bps.upd_pred_taken = 0; bps.upd_pred_target = 32'h44;
        repeat (2) @(posedge CLK);
        #1 nRST = 1; nRST_s = 1;

        for (int k = 0; k < 20; k++) begin
            bpi.en = vt[k].en[0]; bpi.fetch_pc = vt[k].fpc; bpi.upd_valid = vt[k].uv[0];
            bpi.upd_pc = vt[k].upc; bpi.upd_taken = vt[k].ut[0]; bpi.upd_target = vt[k].utgt;
            bpi.upd_pred_taken = vt[k].upt[0]; bpi.upd_pred_target = vt[k].uptgt;
            #1;
            chk($sformatf("v%0d pred_taken", k),  32'(bpi.pred_taken), vt[k].ept);
            chk($sformatf("v%0d pred_target", k), bpi.pred_target, vt[k].eptgt);
            chk($sformatf("v%0d mispredict", k),  32'(bpi.mispredict), vt[k].emis);
            chk($sformatf("v%0d redirect_pc", k), bpi.redirect_pc, vt[k].eredir);
            chk($sformatf("v%0d stat_branches", k), 32'(bpi.stat_branches), vt[k].ebr);
            chk($sformatf("v%0d stat_mispredicts", k), 32'(bpi.stat_mispredicts), vt[k].emc);
            @(posedge CLK);
            #1;
        end

        // Saturating stats, then asynchronous reset in the middle of a cycle.
        bps.en = 1; bps.upd_valid = 1;
        for (int k = 0; k < 20; k++) @(posedge CLK);
        #1;
        chk("sat stat_branches", 32'(bps.stat_branches), 32'd15);
        chk("sat stat_mispredicts", 32'(bps.stat_mispredicts), 32'd15);
        chk("sat pred_taken", 32'(bps.pred_taken), 32'd1);
        bps.upd_valid = 0;
        #1 nRST_s = 0;
        #1;
        chk("async rst stat_branches", 32'(bps.stat_branches), 32'd0);
        chk("async rst stat_mispredicts", 32'(bps.stat_mispredicts), 32'd0);
        chk("async rst pred_taken", 32'(bps.pred_taken), 32'd0);
        chk("async rst pred_target", bps.pred_target, 32'h44);
        nRST_s = 1;
        bps.upd_valid = 1;
        @(posedge CLK);
        #1;
        chk("post rst first update", 32'(bps.stat_branches), 32'd1);
        chk("post rst first pred", 32'(bps.pred_taken), 32'd1);
        bps.upd_valid = 0;

        nRST = 0; m_reset();
        #1 nRST = 1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                nRST = 0; m_reset();
                #1;
                chk("rnd async rst stat_branches", 32'(bpi.stat_branches), 32'd0);
                chk("rnd async rst pred_taken", 32'(bpi.pred_taken), 32'd0);
                nRST = 1;
            end
            bpi.fetch_pc = rand_pc(); bpi.upd_pc = rand_pc(); bpi.upd_target = rand_pc();
            bpi.upd_taken = 1'($urandom_range(0, 1));
            bpi.en = ($urandom_range(0, 3) != 0); bpi.upd_valid = ($urandom_range(0, 4) < 3);
            if ($urandom_range(0, 3) != 0) begin
                bpi.upd_pred_taken = m_pt(bpi.upd_pc); bpi.upd_pred_target = m_ptgt(bpi.upd_pc);
            end else begin
                bpi.upd_pred_taken = 1'($urandom_range(0, 1)); bpi.upd_pred_target = rand_pc();
            end
            #1;
            chk("rnd pred_taken", 32'(bpi.pred_taken), 32'(m_pt(bpi.fetch_pc)));
            chk("rnd pred_target", bpi.pred_target, m_ptgt(bpi.fetch_pc));
            chk("rnd mispredict", 32'(bpi.mispredict), 32'(m_mis()));
            chk("rnd redirect_pc", bpi.redirect_pc, bpi.upd_taken ? bpi.upd_target : bpi.upd_pc + 32'd4);
            chk("rnd stat_branches", 32'(bpi.stat_branches), 32'(m_br));
            chk("rnd stat_mispredicts", 32'(bpi.stat_mispredicts), 32'(m_mc));
            @(posedge CLK);
            m_commit();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
